recursion_stack: RTL and testbench

- Parametrised hardware LIFO that holds return addresses and saved values for the multicycle processor's call/return path.
- Replaces the fixed single-mode stack that sits between MuxPilha (data in) and MuxDadoMem/MuxPC (data out).
- Adds configurable width and depth, an occupancy count, full/empty status, and sticky overflow/underflow error flags.
- Adds a selectable overflow mode (drop or wrap) and a synchronous flush.

---
 rtl/rstack_pkg.sv | 21 ++
 rtl/stack_ram.sv | 36 +++
 rtl/recursion_stack.sv | 148 ++++++++++++++
 tb/tb_recursion_stack.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rstack_pkg.sv
// ============================================================================
// Module      : rstack_pkg
// Description : Shared constants and helpers for the recursion stack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rstack_pkg;

  // Behaviour selected for a push that arrives while the stack is full.
  localparam int OVF_DROP = 0;
  localparam int OVF_WRAP = 1;

  // Width of a pointer that addresses every entry of a DEPTH-deep stack.
  function automatic int ptrWidth(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage : rstack_pkg

`default_nettype wire

// File: rtl/stack_ram.sv
// ============================================================================
// Module      : stack_ram
// Description : DEPTH x DATA_W storage, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_ram
  import rstack_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = ptrWidth(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are deliberately left unreset; the owner masks stale data.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : stack_ram

`default_nettype wire

// File: rtl/recursion_stack.sv
// ============================================================================
// Module      : recursion_stack
// Description : Parametrised call/return LIFO with occupancy, status and
//               sticky error flags; overflow either drops or wraps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module recursion_stack
  import rstack_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int OVF_MODE = OVF_DROP
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic                         clear_err,
  input  logic [DATA_W-1:0]            din,
  output logic [DATA_W-1:0]            dout,
  output logic [ptrWidth(DEPTH):0]     count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int c_ptrW = ptrWidth(DEPTH);
  localparam int c_cntW = c_ptrW + 1;
  localparam logic [c_cntW-1:0] c_fullCount = c_cntW'(DEPTH);
  localparam logic [c_cntW-1:0] c_oneCount  = c_cntW'(1);
  localparam logic [c_ptrW-1:0] c_onePtr    = c_ptrW'(1);
  localparam bit c_wrapEn = (OVF_MODE == OVF_WRAP);

  logic [c_ptrW-1:0] r_topPtr;
  logic [c_cntW-1:0] r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_isEmpty;
  logic              w_isFull;
  logic [c_ptrW-1:0] w_topInc;
  logic [c_ptrW-1:0] w_topDec;
  logic [c_ptrW-1:0] w_nextTop;
  logic [c_cntW-1:0] w_nextCount;
  logic              w_setOvf;
  logic              w_setUdf;
  logic              w_ramWe;
  logic [c_ptrW-1:0] w_ramWaddr;
  logic [DATA_W-1:0] w_ramRdata;

  assign w_isEmpty = (r_count == '0);
  assign w_isFull  = (r_count == c_fullCount);
  assign w_topInc  = r_topPtr + c_onePtr;
  assign w_topDec  = r_topPtr - c_onePtr;

  // Command decode. When full, top+1 is exactly the oldest slot, so a
  // wrapping push overwrites the oldest entry without a separate base pointer.
  always_comb begin
    w_ramWe     = 1'b0;
    w_ramWaddr  = w_topInc;
    w_nextTop   = r_topPtr;
    w_nextCount = r_count;
    w_setOvf    = 1'b0;
    w_setUdf    = 1'b0;
    if (flush) begin
      w_nextTop   = '0;
      w_nextCount = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (!w_isFull) begin
            w_ramWe     = 1'b1;
            w_nextTop   = w_topInc;
            w_nextCount = r_count + c_oneCount;
          end else begin
            w_setOvf = 1'b1;
            if (c_wrapEn) begin
              w_ramWe   = 1'b1;
              w_nextTop = w_topInc;
            end
          end
        end
        2'b01: begin
          if (!w_isEmpty) begin
            w_nextTop   = w_topDec;
            w_nextCount = r_count - c_oneCount;
          end else begin
            w_setUdf = 1'b1;
          end
        end
        2'b11: begin
          w_ramWe = 1'b1;
          if (w_isEmpty) begin
            w_setUdf    = 1'b1;
            w_nextTop   = w_topInc;
            w_nextCount = c_oneCount;
          end else begin
            w_ramWaddr = r_topPtr;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_topPtr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_topPtr    <= w_nextTop;
      r_count     <= w_nextCount;
      // A fresh error outranks a simultaneous clear.
      r_overflow  <= w_setOvf | (r_overflow  & ~clear_err);
      r_underflow <= w_setUdf | (r_underflow & ~clear_err);
    end
  end

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (c_ptrW)
  ) u_stackRam (
    .clk   (clk),
    .we    (w_ramWe),
    .waddr (w_ramWaddr),
    .wdata (din),
    .raddr (r_topPtr),
    .rdata (w_ramRdata)
  );

  assign dout      = w_isEmpty ? '0 : w_ramRdata;
  assign count     = r_count;
  assign empty     = w_isEmpty;
  assign full      = w_isFull;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule : recursion_stack

`default_nettype wire

// File: tb/tb_recursion_stack.sv
// ============================================================================
// Module      : tb_recursion_stack
// Description : Directed self-checking bench; drop- and wrap-mode instances
//               share stimulus and are checked against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_recursion_stack;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst;
  logic              push;
  logic              pop;
  logic              flush;
  logic              clearErr;
  logic [DATA_W-1:0] din;

  logic [DATA_W-1:0] dropDout,  wrapDout;
  logic [4:0]        dropCount, wrapCount;
  logic              dropEmpty, wrapEmpty;
  logic              dropFull,  wrapFull;
  logic              dropOvf,   wrapOvf;
  logic              dropUdf,   wrapUdf;

  int checks   = 0;
  int failures = 0;

  recursion_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OVF_MODE(0)) u_dropDut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
    .clear_err(clearErr), .din(din), .dout(dropDout), .count(dropCount),
    .empty(dropEmpty), .full(dropFull), .overflow(dropOvf), .underflow(dropUdf)
  );

  recursion_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OVF_MODE(1)) u_wrapDut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
    .clear_err(clearErr), .din(din), .dout(wrapDout), .count(wrapCount),
    .empty(wrapEmpty), .full(wrapFull), .overflow(wrapOvf), .underflow(wrapUdf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one command for one clock, then return 1 time unit after the edge.
  task automatic doOp(input logic p, input logic q, input logic f, input logic c,
                      input logic [31:0] d);
    push = p; pop = q; flush = f; clearErr = c; din = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; clearErr = 1'b0; din = '0;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; clearErr = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    checkVal("rst_count", 32'(dropCount), 0);
    checkVal("rst_empty", 32'(dropEmpty), 1);
    checkVal("rst_full",  32'(dropFull),  0);
    checkVal("rst_dout",  dropDout,       0);
    checkVal("rst_ovf",   32'(dropOvf),   0);
    checkVal("rst_udf",   32'(dropUdf),   0);

    // LIFO order with read-before-pop
    doOp(1, 0, 0, 0, 32'h10);
    doOp(1, 0, 0, 0, 32'h20);
    doOp(1, 0, 0, 0, 32'h30);
    checkVal("lifo_top",   dropDout,        32'h30);
    checkVal("lifo_count", 32'(dropCount),  3);
    checkVal("lifo_pop0",  dropDout,        32'h30);
    doOp(0, 1, 0, 0, 0);
    checkVal("lifo_pop1",  dropDout,        32'h20);
    doOp(0, 1, 0, 0, 0);
    checkVal("lifo_pop2",  dropDout,        32'h10);
    doOp(0, 1, 0, 0, 0);
    checkVal("lifo_empty", 32'(dropEmpty),  1);
    checkVal("lifo_dout0", dropDout,        0);
    checkVal("lifo_noudf", 32'(dropUdf),    0);

    // Underflow, clear and push+pop on an empty stack
    doOp(0, 1, 0, 0, 0);
    checkVal("udf_flag",   32'(dropUdf),    1);
    checkVal("udf_count",  32'(dropCount),  0);
    checkVal("udf_dout",   dropDout,        0);
    doOp(0, 0, 0, 1, 0);
    checkVal("udf_clear",  32'(dropUdf),    0);
    doOp(1, 1, 0, 0, 32'h55);
    checkVal("pp_udf",     32'(dropUdf),    1);
    checkVal("pp_count",   32'(dropCount),  1);
    checkVal("pp_dout",    dropDout,        32'h55);
    doOp(0, 1, 0, 0, 0);
    doOp(0, 0, 0, 1, 0);
    doOp(0, 1, 0, 1, 0);
    checkVal("udf_beats_clear", 32'(dropUdf), 1);

    // Overflow in both modes: push 1..18 into 16 entries
    pulseReset();
    checkVal("ar_udf",     32'(dropUdf),    0);
    for (int i = 1; i <= 16; i++) doOp(1, 0, 0, 0, 32'(i));
    checkVal("ovf_full_drop", 32'(dropFull), 1);
    checkVal("ovf_full_wrap", 32'(wrapFull), 1);
    checkVal("ovf_pre_flag",  32'(dropOvf),  0);
    doOp(1, 0, 0, 0, 17);
    doOp(1, 0, 0, 0, 18);
    checkVal("drop_ovf",   32'(dropOvf),    1);
    checkVal("drop_count", 32'(dropCount),  16);
    checkVal("drop_top",   dropDout,        16);
    checkVal("wrap_ovf",   32'(wrapOvf),    1);
    checkVal("wrap_count", 32'(wrapCount),  16);
    checkVal("wrap_top",   wrapDout,        18);
    for (int i = 0; i < 16; i++) begin
      checkVal($sformatf("drop_pop%0d", i), dropDout, 32'(16 - i));
      checkVal($sformatf("wrap_pop%0d", i), wrapDout, 32'(18 - i));
      doOp(0, 1, 0, 0, 0);
    end
    checkVal("drop_drained", 32'(dropEmpty), 1);
    checkVal("wrap_drained", 32'(wrapEmpty), 1);
    checkVal("drain_noudf",  32'(wrapUdf),   0);

    // Replace and flush
    doOp(1, 0, 0, 0, 32'hA);
    doOp(1, 0, 0, 0, 32'hB);
    doOp(1, 1, 0, 0, 32'hC);
    checkVal("rep_count",  32'(dropCount),  2);
    checkVal("rep_dout",   dropDout,        32'hC);
    doOp(0, 1, 0, 0, 0);
    checkVal("rep_under",  dropDout,        32'hA);
    doOp(1, 0, 1, 0, 32'hD);
    checkVal("fl_count",   32'(dropCount),  0);
    checkVal("fl_empty",   32'(dropEmpty),  1);
    checkVal("fl_ovfkeep", 32'(dropOvf),    1);
    checkVal("fl_udf",     32'(dropUdf),    0);
    doOp(1, 1, 1, 0, 32'hE);
    checkVal("fl_pp_udf",  32'(dropUdf),    0);
    checkVal("fl_pp_cnt",  32'(dropCount),  0);

    // Replace while full is legal in both modes
    doOp(0, 0, 0, 1, 0);
    for (int i = 1; i <= 16; i++) doOp(1, 0, 0, 0, 32'(i + 32'h100));
    doOp(1, 1, 0, 0, 32'h77);
    checkVal("frep_drop_ovf", 32'(dropOvf),   0);
    checkVal("frep_wrap_ovf", 32'(wrapOvf),   0);
    checkVal("frep_drop_top", dropDout,       32'h77);
    checkVal("frep_wrap_cnt", 32'(wrapCount), 16);
    doOp(0, 1, 0, 0, 0);
    checkVal("frep_below",    wrapDout,       32'h10F);

    // Reset asserted between clock edges clears state immediately
    doOp(1, 0, 0, 0, 32'h5);
    #2;
    rst = 1'b1;
    #1;
    checkVal("async_count", 32'(dropCount), 0);
    checkVal("async_dout",  dropDout,       0);
    checkVal("async_wrapc", 32'(wrapCount), 0);
    rst = 1'b0;
    doOp(0, 0, 0, 0, 0);
    checkVal("async_empty", 32'(dropEmpty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule : tb_recursion_stack

`default_nettype wire
